tpu_skew_feeder: RTL and testbench

//  Upstream operand feeder for the tpumac systolic array: buffers a DIMxDIM tile of
//  A (or B) operands and streams it diagonally skewed, row i delayed i cycles, so each

---
 rtl/tpu_pkg.sv | 12 +
 rtl/tpu_skew_feeder_if.sv | 27 ++
 rtl/tpu_skew_feeder_skew_row.sv | 60 ++++++
 rtl/tpu_skew_feeder.sv | 109 ++++++++++
 tb/tb_tpu_skew_feeder.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tpu_pkg.sv
// Shared defaults and types for the tpumac operand feeders.
package tpu_pkg;

    localparam int unsigned BITS_AB = 8;
    localparam int unsigned BITS_C  = 16;
    localparam int unsigned DIM     = 8;

    typedef enum logic {IDLE, STREAM} feeder_state_t;

    typedef logic signed [BITS_AB-1:0] operand_t;

endpackage

// File: rtl/tpu_skew_feeder_if.sv
// Handshake/data bundle between a tile loader and one skew feeder instance.
interface tpu_skew_feeder_if #(
    parameter int unsigned BITS_AB = 8,
    parameter int unsigned DIM     = 8
) ();

    logic                       WrEn;
    logic [$clog2(DIM)-1:0]     Arow;
    logic [DIM*BITS_AB-1:0]     Ain;
    logic                       start;
    logic                       en;
    logic [DIM*BITS_AB-1:0]     Aout;
    logic                       busy;
    logic                       done;
    logic                       err;

    modport master (
        output WrEn, Arow, Ain, start, en,
        input  Aout, busy, done, err
    );

    modport slave (
        input  WrEn, Arow, Ain, start, en,
        output Aout, busy, done, err
    );

endinterface

// File: rtl/tpu_skew_feeder_skew_row.sv
// One feeder row: a column shift buffer followed by a DELAY-stage skew chain and output register.
module skew_row #(
    parameter int unsigned BITS_AB = 8,
    parameter int unsigned DIM     = 8,
    parameter int unsigned DELAY   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_wr,
    input  logic [DIM*BITS_AB-1:0] i_wdata,
    input  logic                   i_adv,
    input  logic                   i_clr,
    output logic [BITS_AB-1:0]     o_dout
);

    logic [DIM*BITS_AB-1:0] r_buf;
    logic [BITS_AB-1:0]     w_head;
    logic [BITS_AB-1:0]     r_dout;

    // Column 0 leaves first; zeros refill so a consumed tile reads back empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf <= '0;
        end else if (i_wr) begin
            r_buf <= i_wdata;
        end else if (i_adv) begin
            r_buf <= {{BITS_AB{1'b0}}, r_buf[DIM*BITS_AB-1:BITS_AB]};
        end
    end

    generate
        if (DELAY == 0) begin : g_nodly
            assign w_head = r_buf[BITS_AB-1:0];
        end else begin : g_dly
            logic [BITS_AB-1:0] r_dly [DELAY];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int j = 0; j < int'(DELAY); j++) r_dly[j] <= '0;
                end else if (i_adv) begin
                    r_dly[0] <= r_buf[BITS_AB-1:0];
                    for (int j = 1; j < int'(DELAY); j++) r_dly[j] <= r_dly[j-1];
                end
            end

            assign w_head = r_dly[DELAY-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_dout <= '0;
        end else if (i_adv) begin
            r_dout <= w_head;
        end
    end

    assign o_dout = r_dout;

endmodule

// File: rtl/tpu_skew_feeder.sv
// Skewed operand feeder for one tpumac array edge; SKEW_FEEDER_ERR_EN enables sticky err.
module tpu_skew_feeder
    import tpu_pkg::*;
#(
    parameter int unsigned BITS_AB = tpu_pkg::BITS_AB,
    parameter int unsigned DIM     = tpu_pkg::DIM
) (
    input  logic             clk,
    input  logic             rst,
    tpu_skew_feeder_if.slave bus
);

    localparam int unsigned AW = $clog2(DIM);
    localparam int unsigned CW = $clog2(2 * DIM);
    localparam logic [CW-1:0] LAST_ADV = CW'(2 * DIM - 2);

    feeder_state_t          r_state;
    feeder_state_t          w_state_nxt;
    logic [CW-1:0]          r_cnt;
    logic                   r_done;
    logic                   w_idle;
    logic                   w_busy;
    logic                   w_adv;
    logic                   w_last;
    logic                   w_row_ok;
    logic [DIM-1:0]         w_wr;
    logic [DIM*BITS_AB-1:0] w_aout;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = STREAM;
            STREAM:  if (w_adv && w_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_idle = (r_state == IDLE);
        w_busy = (r_state == STREAM);
        w_adv  = w_busy && bus.en;
        w_last = (r_cnt == LAST_ADV);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_adv && w_last;
            if (w_adv) r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    // Row index can only be out of range when DIM is not a power of two.
    generate
        if ((1 << AW) > DIM) begin : g_row_chk
            assign w_row_ok = (bus.Arow < AW'(DIM));
        end else begin : g_row_all
            assign w_row_ok = 1'b1;
        end
    endgenerate

    generate
        for (genvar i = 0; i < DIM; i++) begin : g_row
            assign w_wr[i] = w_idle && bus.WrEn && w_row_ok && (bus.Arow == AW'(i));

            skew_row #(
                .BITS_AB (BITS_AB),
                .DIM     (DIM),
                .DELAY   (i)
            ) u_row (
                .clk     (clk),
                .rst     (rst),
                .i_wr    (w_wr[i]),
                .i_wdata (bus.Ain),
                .i_adv   (w_adv),
                .i_clr   (w_idle),
                .o_dout  (w_aout[i*BITS_AB +: BITS_AB])
            );
        end
    endgenerate

`ifdef SKEW_FEEDER_ERR_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((w_busy && (bus.WrEn || bus.start)) || (bus.WrEn && !w_row_ok)) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.Aout = w_aout;
    assign bus.busy = w_busy;
    assign bus.done = r_done;

endmodule

// File: tb/tb_tpu_skew_feeder.sv
// Randomized bench for tpu_skew_feeder (DIM=4) against a tile-level reference model.
module tb_tpu_skew_feeder;

    localparam int unsigned BW = 8;
    localparam int unsigned DM = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    tpu_skew_feeder_if #(.BITS_AB(BW), .DIM(DM)) bus ();

    tpu_skew_feeder #(.BITS_AB(BW), .DIM(DM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the tile is a 2-D array; a stream is a snapshot plus an advance count.
    logic [BW-1:0] m_tile [DM][DM];
    logic [BW-1:0] m_snap [DM][DM];
    bit            m_busy;
    int            m_k;
    logic [31:0]   e_aout;
    bit            e_done;
    bit            e_err;
    bit            m_valid;

    task automatic model_step();
        if (rst) begin
            for (int r = 0; r < DM; r++)
                for (int c = 0; c < DM; c++) m_tile[r][c] = '0;
            m_busy = 0; m_k = 0; e_aout = '0; e_done = 0; e_err = 0;
        end else if (!m_busy) begin
            e_done = 0;
            e_aout = '0;
            if (bus.WrEn && int'(bus.Arow) < DM)
                for (int c = 0; c < DM; c++) m_tile[bus.Arow][c] = bus.Ain[c*BW +: BW];
`ifdef SKEW_FEEDER_ERR_EN
            if (bus.WrEn && int'(bus.Arow) >= DM) e_err = 1;
`endif
            if (bus.start) begin
                for (int r = 0; r < DM; r++)
                    for (int c = 0; c < DM; c++) begin
                        m_snap[r][c] = m_tile[r][c];
                        m_tile[r][c] = '0;
                    end
                m_busy = 1;
                m_k = 0;
            end
        end else begin
            e_done = 0;
`ifdef SKEW_FEEDER_ERR_EN
            if (bus.WrEn || bus.start) e_err = 1;
`endif
            if (bus.en) begin
                for (int i = 0; i < DM; i++) begin
                    int col;
                    col = m_k - i;
                    e_aout[i*BW +: BW] = (col >= 0 && col < DM) ? m_snap[i][col] : '0;
                end
                m_k++;
                if (m_k == 2 * DM - 1) begin
                    m_busy = 0;
                    e_done = 1;
                end
            end
        end
    endtask

    // Compare on the falling edge, then predict the next rising edge from the now-stable inputs.
    initial begin
        m_valid = 0;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("model_aout", bus.Aout, e_aout);
                check("model_busy", {31'b0, bus.busy}, {31'b0, m_busy});
                check("model_done", {31'b0, bus.done}, {31'b0, e_done});
                check("model_err", {31'b0, bus.err}, {31'b0, e_err});
            end
            model_step();
            m_valid = 1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write_row(input int r, input logic [31:0] d);
        bus.WrEn = 1'b1;
        bus.Arow = 2'(r);
        bus.Ain  = d;
        cyc();
        bus.WrEn = 1'b0;
    endtask

    task automatic write_seq_tile();
        for (int r = 0; r < DM; r++) begin
            logic [31:0] d;
            for (int c = 0; c < DM; c++) d[c*8 +: 8] = 8'(r * 4 + c + 1);
            write_row(r, d);
        end
    endtask

    task automatic start_stream();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    initial begin
        int adv;
        bit seen;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.WrEn = 1'b0; bus.Arow = '0; bus.Ain = '0; bus.start = 1'b0; bus.en = 1'b0;
        repeat (3) cyc();
        check("reset_aout", bus.Aout, 32'h0);
        check("reset_busy", {31'b0, bus.busy}, 32'h0);
        rst = 1'b0;
        cyc();

        // Sequential tile, en held high
        write_seq_tile();
        bus.en = 1'b1;
        start_stream();
        check("busy_after_start", {31'b0, bus.busy}, 32'h1);
        cyc();
        check("adv0_aout", bus.Aout, 32'h0000_0001);
        repeat (3) cyc();
        check("adv3_aout", bus.Aout, 32'h0D0A_0704);
        repeat (3) cyc();
        check("adv6_aout", bus.Aout, 32'h1000_0000);
        check("adv6_done", {31'b0, bus.done}, 32'h1);
        check("adv6_busy", {31'b0, bus.busy}, 32'h0);
        bus.en = 1'b0;
        cyc();
        check("idle_aout_cleared", bus.Aout, 32'h0);

        // Same tile with stalls
        write_seq_tile();
        start_stream();
        adv = 0;
        seen = 0;
        for (int j = 0; j < 40 && !seen; j++) begin
            bus.en = (j % 4 == 0 || j % 4 == 3);
            cyc();
            if (bus.en) adv++;
            if (bus.done) seen = 1;
        end
        check("stall_done_seen", {31'b0, seen}, 32'h1);
        check("stall_adv_count", 32'(adv), 32'd7);
        bus.en = 1'b0;
        cyc();

        // Only row 2 written, signed extremes
        write_row(2, 32'h00FF_7F80);
        bus.en = 1'b1;
        start_stream();
        repeat (3) cyc();
        check("row2_adv2", {24'b0, bus.Aout[23:16]}, 32'h80);
        repeat (4) cyc();
        bus.en = 1'b0;
        cyc();

        // Write and start in the same cycle
        write_row(1, 32'h0505_0505);
        write_row(2, 32'h0606_0606);
        write_row(3, 32'h0707_0707);
        bus.WrEn = 1'b1; bus.Arow = 2'd0; bus.Ain = 32'h4433_2211; bus.start = 1'b1;
        cyc();
        bus.WrEn = 1'b0; bus.start = 1'b0; bus.en = 1'b1;
        cyc();
        check("wrstart_adv0", {24'b0, bus.Aout[7:0]}, 32'h11);
        repeat (6) cyc();
        bus.en = 1'b0;
        cyc();

        // Reset in the middle of a stream
        write_seq_tile();
        bus.en = 1'b1;
        start_stream();
        repeat (3) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("midrst_aout", bus.Aout, 32'h0);
        check("midrst_busy", {31'b0, bus.busy}, 32'h0);
        check("midrst_done", {31'b0, bus.done}, 32'h0);
        start_stream();
        repeat (7) cyc();
        check("restart_done", {31'b0, bus.done}, 32'h1);
        check("restart_zero", bus.Aout, 32'h0);
        bus.en = 1'b0;
        cyc();

        // Write while busy
        write_seq_tile();
        bus.en = 1'b1;
        start_stream();
        write_row(1, 32'hFFFF_FFFF);
`ifdef SKEW_FEEDER_ERR_EN
        check("busy_write_err", {31'b0, bus.err}, 32'h1);
`else
        check("busy_write_err", {31'b0, bus.err}, 32'h0);
`endif
        repeat (8) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            bus.WrEn  = ($urandom_range(0, 2) == 0);
            bus.Arow  = 2'($urandom_range(0, DM - 1));
            bus.Ain   = $urandom;
            bus.start = ($urandom_range(0, 7) == 0);
            bus.en    = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 199) == 0);
            cyc();
        end
        rst = 1'b0; bus.WrEn = 1'b0; bus.start = 1'b0;
        repeat (2) cyc();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
